// File: rtl/spi_pkg.sv
// Shared types and helpers for the multi-mode SPI master.
// Combinational only (no latency); no flow control.
// Holds the FSM states, the {cpol,cpha} mode codes and a clog2 helper.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        XFER  = 2'd2,
        HOLD  = 2'd3
    } spi_state_t;

    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    // Index width that never collapses to zero bits for tiny counts.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK divider: strobes one SCLK edge every CLK_DIV clk cycles while edge_en is high.
// Latency: edge strobes are combinational; sclk toggles on the clk edge the strobe is seen.
// Backpressure: none; while en is low the counter is cleared and sclk parks at cpol.
module spi_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic edge_en,
    input  logic cpol,
    output logic tick,
    output logic lead_stb,
    output logic trail_stb,
    output logic sclk
);

    localparam int                 CNT_W   = $clog2(CLK_DIV + 1);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] div_cnt;

    assign tick      = en && (div_cnt == CNT_MAX);
    // Leading edge leaves the idle level; trailing edge returns to it.
    assign lead_stb  = tick && edge_en && (sclk == cpol);
    assign trail_stb = tick && edge_en && (sclk != cpol);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (!en || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk <= 1'b0;
        end else if (!en) begin
            sclk <= cpol;
        end else if (lead_stb || trail_stb) begin
            sclk <= ~sclk;
        end
    end

endmodule

// File: rtl/spi_master_mc.sv
// Parametrised full-duplex MSB-first SPI master, all four modes, one-hot active-low selects (SPI_LOOPBACK_EN adds internal loopback).
// Latency: accept edge to done pulse is (2*DATA_W+2)*CLK_DIV clk cycles.
// Backpressure: start is only sampled in IDLE; starts while busy are dropped, bad ss_sel pulses sel_err.
module spi_master_mc
    import spi_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int NUM_SS  = 4,
    parameter int CLK_DIV = 4,
    parameter int SEL_W   = clog2_min1(NUM_SS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [SEL_W-1:0]  ss_sel,
    input  logic [DATA_W-1:0] tx_data,
`ifdef SPI_LOOPBACK_EN
    input  logic              loopback,
`endif
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              done,
    output logic              sel_err,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic [NUM_SS-1:0] ss_n
);

    localparam int                 EDGE_W     = $clog2(2 * DATA_W + 1);
    localparam logic [EDGE_W-1:0]  EDGES      = EDGE_W'(2 * DATA_W);
    localparam logic [EDGE_W-1:0]  LAST_TRAIL = EDGE_W'(2 * DATA_W - 1);
    localparam logic [SEL_W:0]     NUM_SS_V   = (SEL_W + 1)'(NUM_SS);

    spi_state_t        state, state_nxt;
    logic              cpol_q, cpha_q;
    logic [DATA_W-1:0] tx_sr, rx_sr;
    logic [EDGE_W-1:0] edge_cnt;
    logic              tick, lead_stb, trail_stb;
    logic              accept, reject, finish, clk_en, edge_en;
    logic              sel_ok, cpol_eff, sample, shift, rx_bit;

    assign sel_ok = ({1'b0, ss_sel} < NUM_SS_V);
    // Feed the incoming cpol at accept so sclk is at the new idle level on SETUP entry.
    assign cpol_eff = accept ? cpol : cpol_q;

    spi_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (clk_en),
        .edge_en   (edge_en),
        .cpol      (cpol_eff),
        .tick      (tick),
        .lead_stb  (lead_stb),
        .trail_stb (trail_stb),
        .sclk      (sclk)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SETUP;
            SETUP:   if (tick) state_nxt = XFER;
            XFER:    if (tick && (edge_cnt == EDGES)) state_nxt = HOLD;
            HOLD:    if (tick) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        accept  = 1'b0;
        reject  = 1'b0;
        finish  = 1'b0;
        clk_en  = 1'b0;
        edge_en = 1'b0;
        case (state)
            IDLE: begin
                accept = start && sel_ok;
                reject = start && !sel_ok;
            end
            SETUP: begin
                clk_en  = 1'b1;
                edge_en = 1'b1;
            end
            XFER: begin
                clk_en  = 1'b1;
                edge_en = (edge_cnt != EDGES);
            end
            HOLD: begin
                clk_en = 1'b1;
                finish = tick;
            end
            default: ;
        endcase
    end

    // CPHA=0 presents the MSB at select time, so the last trailing edge has nothing left to shift.
    assign sample = cpha_q ? trail_stb : lead_stb;
    assign shift  = cpha_q ? lead_stb  : (trail_stb && (edge_cnt != LAST_TRAIL));

`ifdef SPI_LOOPBACK_EN
    logic lb_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lb_q <= 1'b0;
        end else if (accept) begin
            lb_q <= loopback;
        end
    end
    assign rx_bit = lb_q ? mosi : miso;
`else
    assign rx_bit = miso;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt <= '0;
        end else if (accept) begin
            edge_cnt <= '0;
        end else if (lead_stb || trail_stb) begin
            edge_cnt <= edge_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            tx_sr   <= '0;
            rx_sr   <= '0;
            mosi    <= 1'b0;
            rx_data <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sel_err <= 1'b0;
            ss_n    <= '1;
        end else begin
            done    <= finish;
            sel_err <= reject;
            if (accept) begin
                cpol_q <= cpol;
                cpha_q <= cpha;
                busy   <= 1'b1;
                ss_n   <= ~(NUM_SS'(1) << ss_sel);
                rx_sr  <= '0;
                if (cpha) begin
                    tx_sr <= tx_data;
                end else begin
                    tx_sr <= {tx_data[DATA_W-2:0], 1'b0};
                    mosi  <= tx_data[DATA_W-1];
                end
            end else begin
                if (shift) begin
                    mosi  <= tx_sr[DATA_W-1];
                    tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
                end
                if (sample) begin
                    rx_sr <= {rx_sr[DATA_W-2:0], rx_bit};
                end
                if (finish) begin
                    busy    <= 1'b0;
                    ss_n    <= '1;
                    rx_data <= rx_sr;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_master_mc.sv
// Bench for spi_master_mc: scoreboarded transfers against an independent SPI slave model.
// A second instance with NUM_SS=3 exercises the invalid-select path.
module tb_spi_master_mc;
    import spi_pkg::*;

    typedef struct packed {
        logic [7:0] rx;
        logic [7:0] mo;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, cpol = 1'b0, cpha = 1'b0;
    logic [1:0] ss_sel = 2'd0;
    logic [7:0] tx_data = 8'h00;
    logic [7:0] rx_data;
    logic       busy, done, sel_err, sclk, mosi;
    logic       miso = 1'b0;
    logic [3:0] ss_n;
`ifdef SPI_LOOPBACK_EN
    logic       loopback = 1'b0;
`endif

    logic       start1 = 1'b0;
    logic [1:0] ss_sel1 = 2'd0;
    logic [7:0] rx_data1;
    logic       busy1, done1, sel_err1, sclk1, mosi1;
    logic [2:0] ss_n1;

    int   total = 0, bad = 0;
    int   cyc = 0, acc_cyc = 0, n_done = 0, n_done1 = 0;
    logic busy_d = 1'b0;
    exp_t sb[$];

    // Slave model state
    logic [7:0] s_tx = 8'h00, s_rx = 8'h00;
    int         s_idx = 0;
    logic       s_on = 1'b0, s_prev = 1'b0, m_cpol = 1'b0, m_cpha = 1'b0;
    wire        sel_act = ~&ss_n;

    always #5 clk = ~clk;

    spi_master_mc #(.DATA_W(8), .NUM_SS(4), .CLK_DIV(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cpol(cpol), .cpha(cpha),
        .ss_sel(ss_sel), .tx_data(tx_data),
`ifdef SPI_LOOPBACK_EN
        .loopback(loopback),
`endif
        .rx_data(rx_data), .busy(busy), .done(done), .sel_err(sel_err),
        .sclk(sclk), .mosi(mosi), .miso(miso), .ss_n(ss_n)
    );

    spi_master_mc #(.DATA_W(8), .NUM_SS(3), .CLK_DIV(4)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start1), .cpol(1'b0), .cpha(1'b0),
        .ss_sel(ss_sel1), .tx_data(8'h5A),
`ifdef SPI_LOOPBACK_EN
        .loopback(1'b0),
`endif
        .rx_data(rx_data1), .busy(busy1), .done(done1), .sel_err(sel_err1),
        .sclk(sclk1), .mosi(mosi1), .miso(1'b0), .ss_n(ss_n1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Standard SPI slave: presents miso and captures mosi according to CPOL/CPHA.
    always @(posedge clk) begin
        #1;
        if (!sel_act) begin
            s_on = 1'b0;
        end else if (!s_on) begin
            s_on   = 1'b1;
            s_idx  = 0;
            s_prev = m_cpol;
            s_rx   = 8'h00;
            if (!m_cpha) miso = s_tx[7];
        end else if (sclk != s_prev) begin
            s_prev = sclk;
            if (sclk != m_cpol) begin
                if (!m_cpha) s_rx = {s_rx[6:0], mosi};
                else         miso = s_tx[7 - s_idx];
            end else begin
                if (!m_cpha) begin
                    s_idx++;
                    if (s_idx < 8) miso = s_tx[7 - s_idx];
                end else begin
                    s_rx = {s_rx[6:0], mosi};
                    s_idx++;
                end
            end
        end
    end

    // Output monitor: pops the scoreboard on every done pulse.
    always @(posedge clk) begin
        exp_t e;
        #1;
        cyc++;
        if (busy && !busy_d) acc_cyc = cyc;
        busy_d = busy;
        if (done1) n_done1++;
        if (done) begin
            n_done++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("rx_data", rx_data, e.rx);
                chk("slave_mosi", s_rx, e.mo);
                chk("latency", cyc - acc_cyc, 72);
                chk("ss_n_done", ss_n, 4'hF);
                chk("busy_done", busy, 1'b0);
                chk("no_sel_err_with_done", sel_err, 1'b0);
            end
        end
    end

    task automatic wait_done(input int target);
        int k = 0;
        while (n_done < target && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk("done_seen", n_done >= target, 1'b1);
    endtask

    task automatic run_xfer(input logic [1:0] mode, input logic [1:0] sel,
                            input logic [7:0] tx, input logic [7:0] srsp,
                            input logic [7:0] exp_rx);
        exp_t e;
        int   n0;
        logic [3:0] exp_ss;
        exp_ss = ~(4'b0001 << sel);
        m_cpol = mode[1];
        m_cpha = mode[0];
        s_tx   = srsp;
        e.rx = exp_rx;
        e.mo = tx;
        sb.push_back(e);
        n0 = n_done;
        @(negedge clk);
        start = 1'b1; cpol = mode[1]; cpha = mode[0]; ss_sel = sel; tx_data = tx;
        @(negedge clk);
        start = 1'b0;
        chk("busy_accept", busy, 1'b1);
        chk("sclk_setup", sclk, mode[1]);
        if (!mode[0]) chk("mosi_msb_setup", mosi, tx[7]);
        cpol = ~cpol; cpha = ~cpha; tx_data = ~tx; ss_sel = sel + 2'd1;
        repeat (10) @(negedge clk);
        chk("ss_n_frame", ss_n, exp_ss);
        wait_done(n0 + 1);
        repeat (3) @(negedge clk);
        chk("sclk_idle", sclk, mode[1]);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: run did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   n0, k;
        repeat (3) @(negedge clk);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_sel_err", sel_err, 1'b0);
        chk("rst_sclk", sclk, 1'b0);
        chk("rst_mosi", mosi, 1'b0);
        chk("rst_ss_n", ss_n, 4'hF);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_xfer(SPI_MODE0, 2'd2, 8'hA5, 8'h3C, 8'h3C);
        run_xfer(SPI_MODE1, 2'd1, 8'h81, 8'h7E, 8'h7E);
        run_xfer(SPI_MODE2, 2'd0, 8'h81, 8'h7E, 8'h7E);
        run_xfer(SPI_MODE3, 2'd3, 8'h81, 8'h7E, 8'h7E);

        // Back-to-back with start held high
        m_cpol = 1'b0; m_cpha = 1'b0; s_tx = 8'h5A;
        e.rx = 8'h5A; e.mo = 8'h11; sb.push_back(e);
        e.rx = 8'h5A; e.mo = 8'h22; sb.push_back(e);
        n0 = n_done;
        @(negedge clk);
        start = 1'b1; cpol = 1'b0; cpha = 1'b0; ss_sel = 2'd1; tx_data = 8'h11;
        @(negedge clk);
        chk("b2b_busy1", busy, 1'b1);
        tx_data = 8'h22;
        k = 0;
        while (n_done < n0 + 1 && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk("b2b_gap_ss_n", ss_n, 4'hF);
        chk("b2b_gap_busy", busy, 1'b0);
        @(negedge clk);
        chk("b2b_second_accept", busy, 1'b1);
        chk("b2b_ss_n2", ss_n, 4'hD);
        wait_done(n0 + 2);
        start = 1'b0;
        repeat (100) @(negedge clk);
        chk("b2b_frame_count", n_done - n0, 2);
        chk("b2b_idle", busy, 1'b0);

        // Invalid select on the 3-slave instance
        @(negedge clk);
        start1 = 1'b1; ss_sel1 = 2'd3;
        @(negedge clk);
        start1 = 1'b0;
        chk("sel_err_pulse", sel_err1, 1'b1);
        chk("sel_err_busy", busy1, 1'b0);
        chk("sel_err_ss_n", ss_n1, 3'b111);
        @(negedge clk);
        chk("sel_err_one_cycle", sel_err1, 1'b0);
        repeat (90) @(negedge clk);
        chk("sel_err_no_done", n_done1, 0);
        chk("sel_err_no_sclk", sclk1, 1'b0);
        chk("sel_err_no_mosi", mosi1, 1'b0);
        chk("sel_err_no_rx", rx_data1, 8'h00);

        // Reset roughly 30 cycles into a frame
        m_cpol = 1'b1; m_cpha = 1'b1; s_tx = 8'h99;
        @(negedge clk);
        start = 1'b1; cpol = 1'b1; cpha = 1'b1; ss_sel = 2'd0; tx_data = 8'h66;
        @(negedge clk);
        start = 1'b0;
        repeat (29) @(negedge clk);
        chk("pre_rst_busy", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ss_n", ss_n, 4'hF);
        chk("arst_sclk", sclk, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_rx_data", rx_data, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_xfer(SPI_MODE2, 2'd3, 8'h3C, 8'hA5, 8'hA5);

`ifdef SPI_LOOPBACK_EN
        loopback = 1'b1;
        run_xfer(SPI_MODE0, 2'd0, 8'hC3, 8'h00, 8'hC3);
        loopback = 1'b0;
`endif

        chk("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_master_mc.md
Name: spi_master_mc

Overview:
- Parametrised successor to the team's fixed 8-bit SPI master.
- Supports configurable frame width, programmable SCLK divider, all four SPI modes (CPOL/CPHA, selected per transfer) and NUM_SS one-hot active-low slave selects.
- Sits between a local controller (start/busy/done handshake) and the SPI pins.
- Full-duplex, MSB first.

Parameters:
- DATA_W, 8: frame width in bits; must be ≥2.
- NUM_SS, 4: number of slave-select lines; must be ≥1.
- CLK_DIV, 4: clk cycles per SCLK half-period; must be ≥1.
- SEL_W, $clog2(NUM_SS) (min 1): width of ss_sel. Derived; do not override.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a transfer; sampled only in IDLE.
- cpol  in  1  clock polarity; latched at accept.
- cpha  in  1  clock phase; latched at accept.
- ss_sel  in  SEL_W  target slave index; latched at accept.
- tx_data  in  DATA_W  frame to send; latched at accept.
- rx_data  out  DATA_W  last received frame.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse at end of frame.
- sel_err  out  1  one-cycle pulse when start is rejected for an invalid ss_sel.
- sclk  out  1  SPI clock.
- mosi  out  1  master out.
- miso  in  1  master in.
- ss_n  out  NUM_SS  active-low selects, at most one low.

Behaviour:
- Reset values: rx_data=0, busy=0, done=0, sel_err=0, sclk=0, mosi=0, ss_n=all 1, state=IDLE, latched cpol/cpha=0.
- FSM states: IDLE, SETUP, XFER, HOLD.
- IDLE:
  - sclk = latched cpol.
  - start=1 with ss_sel<NUM_SS → accept: latch tx_data/cpol/cpha/ss_sel. Next cycle: state=SETUP, busy=1, ss_n[ss_sel]=0, sclk=new cpol.
  - start=1 with ss_sel≥NUM_SS → no accept; sel_err=1 for one cycle; state stays IDLE.
- SETUP:
  - Lasts CLK_DIV cycles.
  - CPHA=0: mosi = tx MSB from SETUP entry.
  - CPHA=1: mosi updates on the first SCLK edge.
- XFER:
  - 2*DATA_W SCLK edges, spaced CLK_DIV clk cycles apart; first edge at SETUP→XFER.
  - Leading edge: idle→active. Trailing edge: active→idle.
  - CPHA=0: sample miso on leading edge; shift mosi on trailing edge, except the final trailing edge.
  - CPHA=1: shift mosi on leading edge; sample miso on trailing edge.
  - Received bits shift in MSB first.
- HOLD:
  - Lasts CLK_DIV cycles; sclk = cpol.
  - At exit: ss_n all 1, busy=0, done=1, rx_data updated, state=IDLE. All in the same cycle.
- Latency: accept edge at cycle 0 → done at cycle (2*DATA_W+2)*CLK_DIV. For DATA_W=8, CLK_DIV=4: cycle 72.
- done and sel_err are never asserted together.
- rx_data holds its value until the next done.
- start while busy=1 is ignored: no queueing, no error.
- start held high through the done cycle: a new transfer is accepted in the cycle after done (back-to-back). ss_n deasserts for at least one cycle between frames.
- Changing cpol/cpha/tx_data/ss_sel mid-transfer has no effect.
- Asynchronous reset mid-frame: immediately ss_n=all 1, sclk=0, busy=0. Partial rx bits are discarded; rx_data=0.
- Divider counter width: $clog2(CLK_DIV+1). Bit counter width: $clog2(2*DATA_W+1).

Optional Feature:
- SPI_LOOPBACK_EN defined:
  - Adds input port loopback (1 bit).
  - When loopback=1 (latched at accept), the receive shifter samples internal mosi instead of miso. ss_n and sclk still toggle normally.
  - Result: rx_data == tx_data after done.
- Not defined: port absent; miso is always used.

Decomposition:
- Shared package spi_pkg:
  - State enum (IDLE/SETUP/XFER/HOLD).
  - Mode encoding constants SPI_MODE0..3 = {cpol,cpha}.
  - Helper function for clog2-minimum-1.
- One natural sub-module: spi_clk_gen.
  - Divider counter; produces edge strobes lead_stb/trail_stb and sclk level from cpol and an enable.
  - FSM and shifters stay in spi_master_mc.

Test Plan:
- Mode 0, DATA_W=8, CLK_DIV=4, ss_sel=2, tx=0xA5, slave model returns 0x3C:
  - mosi bit sequence 1,0,1,0,0,1,0,1.
  - ss_n=4'b1011 during frame.
  - done at cycle 72; rx_data=0x3C.
- Modes 1, 2, 3 each with tx=0x81, slave returns 0x7E:
  - idle sclk equals cpol.
  - sample/shift edges match the CPHA rule.
  - rx_data=0x7E in each mode.
- start held high for 2 frames (tx=0x11 then 0x22):
  - second accept in the cycle after the first done.
  - ss_n high for ≥1 cycle between frames.
  - start during busy ignored.
- ss_sel=3 with NUM_SS=3:
  - sel_err pulse one cycle; busy stays 0; ss_n stays all 1; no done.
- rst_n low at cycle 30 of a frame:
  - same-cycle ss_n=all 1, sclk=0, busy=0, rx_data=0.
  - next start completes normally.
- SPI_LOOPBACK_EN defined, loopback=1, tx=0xC3, miso tied 0:
  - rx_data=0xC3.
